// File: rtl/elevator_pkg.sv
// Shared types and constants for the single-car elevator controller.
// Holds the FSM state encoding, the request type codes and the reset position.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic [1:0] REQ_CAR  = 2'd0;
  localparam logic [1:0] REQ_UP   = 2'd1;
  localparam logic [1:0] REQ_DOWN = 2'd2;
  localparam logic [1:0] REQ_RSVD = 2'd3;

  localparam int   RESET_FLOOR  = 0;
  localparam logic RESET_DIR_UP = 1'b1;

endpackage

// File: rtl/elevator_call_bank.sv
// Car / hall-up / hall-down call bitmaps with one set port and a per-type clear at one floor.
// Sets and clears land on the next edge; lookups against q_floor are combinational.
module elevator_call_bank
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = 8,
  parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_vld,
  input  logic [FLOOR_W-1:0]  set_floor,
  input  logic [1:0]          set_type,
  input  logic [FLOOR_W-1:0]  clr_floor,
  input  logic                clr_car,
  input  logic                clr_up,
  input  logic                clr_down,
  input  logic [FLOOR_W-1:0]  q_floor,
  output logic                any_above,
  output logic                any_below,
  output logic                hit_car,
  output logic                hit_up,
  output logic                hit_down,
  output logic [N_FLOORS-1:0] pending
);

  logic [N_FLOORS-1:0] car_q, up_q, dn_q;
  logic [N_FLOORS-1:0] set_car, set_up, set_dn;
  logic [N_FLOORS-1:0] clr_car_m, clr_up_m, clr_dn_m;

  assign pending = car_q | up_q | dn_q;

  always_comb begin
    for (int i = 0; i < N_FLOORS; i++) begin
      set_car[i]   = set_vld && (set_type == REQ_CAR)  && (int'(set_floor) == i);
      set_up[i]    = set_vld && (set_type == REQ_UP)   && (int'(set_floor) == i);
      set_dn[i]    = set_vld && (set_type == REQ_DOWN) && (int'(set_floor) == i);
      clr_car_m[i] = clr_car  && (int'(clr_floor) == i);
      clr_up_m[i]  = clr_up   && (int'(clr_floor) == i);
      clr_dn_m[i]  = clr_down && (int'(clr_floor) == i);
    end
  end

  // Reductions exclude the query floor itself.
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    hit_car   = 1'b0;
    hit_up    = 1'b0;
    hit_down  = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(q_floor)) any_above = any_above | pending[i];
      if (i < int'(q_floor)) any_below = any_below | pending[i];
      if (i == int'(q_floor)) begin
        hit_car  = car_q[i];
        hit_up   = up_q[i];
        hit_down = dn_q[i];
      end
    end
  end

  // Clear wins only on the bit being serviced; all other bits set normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
    end else begin
      car_q <= (car_q | set_car) & ~clr_car_m;
      up_q  <= (up_q  | set_up)  & ~clr_up_m;
      dn_q  <= (dn_q  | set_dn)  & ~clr_dn_m;
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car LOOK elevator: request validation, travel/door timing, stop decisions.
// Requests are taken every cycle (no backpressure); a call at another floor starts motion 2 cycles later.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS      = 8,
  parameter int FLOOR_W       = $clog2(N_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [FLOOR_W-1:0]  req_floor,
  input  logic [1:0]          req_type,
  output logic                req_err,
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic                dir_up,
  output logic                moving,
  output logic                door_open,
  output logic                arrive,
  output logic [N_FLOORS-1:0] pending
);

  localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               req_ok, door_hold, set_vld;
  logic               step, open_now, flip_now, new_dir;
  logic [FLOOR_W-1:0] next_floor, q_floor;
  logic               any_above, any_below, hit_car, hit_up, hit_down;
  logic               ahead, behind, hit_dir, hit_opp;

  always_comb begin
    req_ok = req_valid && (int'(req_floor) < N_FLOORS) && (req_type != REQ_RSVD)
             && !((req_type == REQ_UP)   && (req_floor == TOP_FLOOR))
             && !((req_type == REQ_DOWN) && (req_floor == '0));
    // A repeat of a call already being served here keeps the door open instead of latching.
    door_hold = (state == DOOR) && req_ok && (req_floor == cur_floor)
                && ((req_type == REQ_CAR) || (req_type == (dir_up ? REQ_UP : REQ_DOWN)));
    set_vld = req_ok && !door_hold;
  end

  // While a travel step expires, all lookups are made against the floor being entered.
  always_comb begin
    step = (state == MOVE) && (cnt == '0);
    if (dir_up) next_floor = (cur_floor == TOP_FLOOR) ? cur_floor : cur_floor + FLOOR_W'(1);
    else        next_floor = (cur_floor == '0)        ? cur_floor : cur_floor - FLOOR_W'(1);
    q_floor = step ? next_floor : cur_floor;
    ahead   = dir_up ? any_above : any_below;
    behind  = dir_up ? any_below : any_above;
    hit_dir = dir_up ? hit_up    : hit_down;
    hit_opp = dir_up ? hit_down  : hit_up;
  end

  always_comb begin
    open_now = 1'b0;
    flip_now = 1'b0;
    if ((state == IDLE) || step) begin
      if (hit_car || hit_dir) begin
        open_now = 1'b1;
      end else if (hit_opp && !ahead) begin
        open_now = 1'b1;
        flip_now = 1'b1;
      end
    end
    new_dir = dir_up ^ flip_now;
  end

  elevator_call_bank #(
    .N_FLOORS (N_FLOORS),
    .FLOOR_W  (FLOOR_W)
  ) u_calls (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_vld   (set_vld),
    .set_floor (req_floor),
    .set_type  (req_type),
    .clr_floor (q_floor),
    .clr_car   (open_now),
    .clr_up    (open_now && new_dir),
    .clr_down  (open_now && !new_dir),
    .q_floor   (q_floor),
    .any_above (any_above),
    .any_below (any_below),
    .hit_car   (hit_car),
    .hit_up    (hit_up),
    .hit_down  (hit_down),
    .pending   (pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_floor <= FLOOR_W'(RESET_FLOOR);
      dir_up    <= RESET_DIR_UP;
      moving    <= 1'b0;
      door_open <= 1'b0;
      arrive    <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      req_err <= req_valid && !req_ok;
      arrive  <= 1'b0;
      case (state)
        IDLE: begin
          if (open_now) begin
            state     <= DOOR;
            cnt       <= DOOR_LOAD;
            dir_up    <= new_dir;
            door_open <= 1'b1;
          end else if (ahead || behind) begin
            state  <= MOVE;
            cnt    <= TRAVEL_LOAD;
            dir_up <= ahead ? dir_up : !dir_up;
            moving <= 1'b1;
          end
        end
        MOVE: begin
          if (!step) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cur_floor <= next_floor;
            if (open_now) begin
              state     <= DOOR;
              cnt       <= DOOR_LOAD;
              dir_up    <= new_dir;
              moving    <= 1'b0;
              door_open <= 1'b1;
              arrive    <= 1'b1;
            end else if (ahead) begin
              cnt <= TRAVEL_LOAD;
            end else begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end
        end
        DOOR: begin
          if (door_hold) begin
            cnt <= DOOR_LOAD;
          end else if (cnt == '0) begin
            state     <= IDLE;
            door_open <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: vector table, directed corner sequences, and random traffic vs a model.
module tb_elevator_ctrl;
  localparam int NF   = 8;
  localparam int TRAV = 2;
  localparam int DOOR = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid;
  logic [2:0] req_floor;
  logic [1:0] req_type;
  logic       req_err, dir_up, moving, door_open, arrive;
  logic [2:0] cur_floor;
  logic [7:0] pending;

  logic       e6_valid;
  logic [2:0] e6_floor_in;
  logic [1:0] e6_type;
  logic       e6_err, e6_dir, e6_mov, e6_door, e6_arr;
  logic [2:0] e6_cur;
  logic [5:0] e6_pend;

  int n_chk = 0;
  int n_err = 0;

  elevator_ctrl #(.N_FLOORS(NF), .TRAVEL_CYCLES(TRAV), .DOOR_CYCLES(DOOR)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_floor(req_floor), .req_type(req_type),
    .req_err(req_err), .cur_floor(cur_floor), .dir_up(dir_up), .moving(moving),
    .door_open(door_open), .arrive(arrive), .pending(pending)
  );

  elevator_ctrl #(.N_FLOORS(6), .TRAVEL_CYCLES(TRAV), .DOOR_CYCLES(DOOR)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(e6_valid), .req_floor(e6_floor_in), .req_type(e6_type),
    .req_err(e6_err), .cur_floor(e6_cur), .dir_up(e6_dir), .moving(e6_mov),
    .door_open(e6_door), .arrive(e6_arr), .pending(e6_pend)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f, input logic [1:0] t);
    req_valid = v;
    req_floor = f;
    req_type  = t;
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd0, 2'd0);
    e6_valid = 1'b0; e6_floor_in = 3'd0; e6_type = 2'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", {cur_floor, dir_up, moving, door_open, arrive, req_err, pending},
        {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b1;
  endtask

  task automatic wait_arrive(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (arrive) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic e6_req(input logic [2:0] f, input logic [1:0] t, input logic exp_err,
                        input logic [5:0] exp_pend);
    e6_valid = 1'b1; e6_floor_in = f; e6_type = t;
    tick();
    e6_valid = 1'b0;
    chk($sformatf("n6 req f%0d t%0d err", f, t), e6_err, exp_err);
    chk($sformatf("n6 req f%0d t%0d pending", f, t), e6_pend, exp_pend);
  endtask

  // Reference model: call sets as arrays, car position and phase timing counted in plain ints.
  typedef enum {PH_IDLE, PH_MOVE, PH_DOOR} ph_t;
  bit  cc[NF], hu[NF], hd[NF];
  int  m_floor, m_el;
  bit  m_dirup, m_arr, m_err;
  ph_t m_ph;

  function automatic bit calls_beyond(int fl, bit up);
    for (int i = 0; i < NF; i++)
      if ((up ? (i > fl) : (i < fl)) && (cc[i] || hu[i] || hd[i])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit hall_at(int fl, bit up);
    return up ? hu[fl] : hd[fl];
  endfunction

  function automatic logic [7:0] m_pending();
    logic [7:0] p;
    for (int i = 0; i < NF; i++) p[i] = cc[i] | hu[i] | hd[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin cc[i] = 0; hu[i] = 0; hd[i] = 0; end
    m_floor = 0; m_el = 0; m_dirup = 1'b1; m_arr = 0; m_err = 0; m_ph = PH_IDLE;
  endtask

  task automatic model_edge(input bit v, input int f, input int t);
    bit ok, hold, open, flip;
    int fl;
    ok   = v && (f < NF) && (t != 3) && !(t == 1 && f == NF - 1) && !(t == 2 && f == 0);
    hold = (m_ph == PH_DOOR) && ok && (f == m_floor) && (t == 0 || t == (m_dirup ? 1 : 2));
    m_err = v && !ok;
    m_arr = 1'b0;
    open = 1'b0; flip = 1'b0; fl = m_floor;
    case (m_ph)
      PH_IDLE: begin
        if (cc[fl] || hall_at(fl, m_dirup)) open = 1'b1;
        else if (calls_beyond(fl, m_dirup)) begin m_ph = PH_MOVE; m_el = 0; end
        else if (hall_at(fl, !m_dirup)) begin open = 1'b1; flip = 1'b1; end
        else if (calls_beyond(fl, !m_dirup)) begin m_dirup = !m_dirup; m_ph = PH_MOVE; m_el = 0; end
      end
      PH_MOVE: begin
        m_el++;
        if (m_el == TRAV) begin
          fl = m_dirup ? m_floor + 1 : m_floor - 1;
          m_floor = fl;
          m_el = 0;
          if (cc[fl] || hall_at(fl, m_dirup)) begin open = 1'b1; m_arr = 1'b1; end
          else if (hall_at(fl, !m_dirup) && !calls_beyond(fl, m_dirup)) begin
            open = 1'b1; flip = 1'b1; m_arr = 1'b1;
          end else if (!calls_beyond(fl, m_dirup)) m_ph = PH_IDLE;
        end
      end
      default: begin
        if (hold) m_el = 0;
        else begin
          m_el++;
          if (m_el == DOOR) m_ph = PH_IDLE;
        end
      end
    endcase
    if (open) begin
      if (flip) m_dirup = !m_dirup;
      m_ph = PH_DOOR;
      m_el = 0;
    end
    if (ok && !hold) begin
      if (t == 0) cc[f] = 1'b1;
      else if (t == 1) hu[f] = 1'b1;
      else hd[f] = 1'b1;
    end
    if (open) begin
      cc[fl] = 1'b0;
      if (m_dirup) hu[fl] = 1'b0; else hd[fl] = 1'b0;
    end
  endtask

  typedef struct packed {
    logic       vld;
    logic [2:0] fl;
    logic [1:0] ty;
    logic       err;
    logic [7:0] pend;
  } vec_t;
  vec_t tbl[9];

  initial begin
    bit ok;
    tbl[0] = '{1'b1, 3'd7, 2'd1, 1'b1, 8'h00};
    tbl[1] = '{1'b1, 3'd0, 2'd2, 1'b1, 8'h00};
    tbl[2] = '{1'b1, 3'd4, 2'd3, 1'b1, 8'h00};
    tbl[3] = '{1'b0, 3'd4, 2'd0, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 3'd7, 2'd2, 1'b0, 8'h80};
    tbl[5] = '{1'b1, 3'd7, 2'd3, 1'b1, 8'h80};
    tbl[6] = '{1'b1, 3'd7, 2'd2, 1'b0, 8'h80};
    tbl[7] = '{1'b1, 3'd2, 2'd0, 1'b0, 8'h84};
    tbl[8] = '{1'b1, 3'd6, 2'd1, 1'b0, 8'hC4};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].vld, tbl[i].fl, tbl[i].ty);
      tick();
      chk($sformatf("vec%0d req_err", i), req_err, tbl[i].err);
      chk($sformatf("vec%0d pending", i), pending, tbl[i].pend);
    end
    drive(1'b0, 3'd0, 2'd0);

    // Single car call from floor 0 to 5.
    do_reset();
    drive(1'b1, 3'd5, 2'd0);
    tick();
    drive(1'b0, 3'd0, 2'd0);
    chk("car5 latched", {moving, pending}, {1'b0, 8'h20});
    tick();
    chk("car5 moving after 2", moving, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      tick();
      chk($sformatf("car5 floor step %0d", k), cur_floor, k);
      if (k < 5) chk($sformatf("car5 still moving %0d", k), {moving, arrive}, 2'b10);
    end
    chk("car5 arrive", {arrive, door_open, moving, pending}, {1'b1, 1'b1, 1'b0, 8'h00});
    repeat (3) tick();
    chk("car5 door last cycle", {door_open, arrive}, 2'b10);
    tick();
    chk("car5 back to idle", {door_open, moving}, 2'b00);

    // Door reload by a repeat call during the third door cycle.
    do_reset();
    drive(1'b1, 3'd0, 2'd0);
    tick();
    drive(1'b0, 3'd0, 2'd0);
    chk("reload call latched", pending, 8'h01);
    tick();
    chk("reload door opens", {door_open, arrive, pending}, {1'b1, 1'b0, 8'h00});
    tick();
    tick();
    drive(1'b1, 3'd0, 2'd0);
    tick();
    drive(1'b0, 3'd0, 2'd0);
    chk("reload not latched", {door_open, pending}, {1'b1, 8'h00});
    tick();
    chk("reload door held past original close", door_open, 1'b1);
    tick();
    tick();
    chk("reload door 4th extra cycle", door_open, 1'b1);
    tick();
    chk("reload door closes", door_open, 1'b0);

    // Car 6 plus both hall calls at 3: up-stop at 3, on to 6, reverse, down-stop at 3.
    do_reset();
    drive(1'b1, 3'd6, 2'd0); tick();
    drive(1'b1, 3'd3, 2'd1); tick();
    drive(1'b1, 3'd3, 2'd2); tick();
    drive(1'b0, 3'd0, 2'd0);
    wait_arrive(60, ok);
    chk("hall3 first arrive seen", ok, 1'b1);
    chk("hall3 first stop", {cur_floor, dir_up, pending}, {3'd3, 1'b1, 8'h48});
    wait_arrive(60, ok);
    chk("hall3 second arrive seen", ok, 1'b1);
    chk("hall3 stop at 6", {cur_floor, dir_up, pending}, {3'd6, 1'b1, 8'h08});
    wait_arrive(60, ok);
    chk("hall3 third arrive seen", ok, 1'b1);
    chk("hall3 down stop", {cur_floor, dir_up, pending}, {3'd3, 1'b0, 8'h00});

    // Asynchronous reset between floors 2 and 3.
    do_reset();
    drive(1'b1, 3'd5, 2'd0); tick();
    drive(1'b0, 3'd0, 2'd0); tick();
    repeat (4) tick();
    chk("pre-reset at floor 2 moving", {cur_floor, moving}, {3'd2, 1'b1});
    tick();
    rst_n = 1'b0;
    #1;
    chk("async reset immediate", {cur_floor, dir_up, moving, door_open, arrive, pending},
        {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    #2;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post-reset stays idle", {cur_floor, moving, door_open, pending}, {3'd0, 1'b0, 1'b0, 8'h00});

    // Out-of-range floors on a 6-floor car.
    do_reset();
    e6_req(3'd6, 2'd0, 1'b1, 6'h00);
    e6_req(3'd7, 2'd1, 1'b1, 6'h00);
    e6_req(3'd5, 2'd1, 1'b1, 6'h00);
    e6_req(3'd3, 2'd3, 1'b1, 6'h00);
    e6_req(3'd5, 2'd0, 1'b0, 6'h20);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000 && n_err < 10; c++) begin
      bit v;
      int f, t;
      v = ($urandom_range(0, 5) == 0);
      f = $urandom_range(0, 7);
      t = $urandom_range(0, 3);
      drive(v, 3'(f), 2'(t));
      tick();
      model_edge(v, f, t);
      chk($sformatf("random c%0d", c),
          {cur_floor, dir_up, moving, door_open, arrive, req_err, pending},
          {3'(m_floor), m_dirup, m_ph == PH_MOVE, m_ph == PH_DOOR, m_arr, m_err, m_pending()});
    end
    drive(1'b0, 3'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
